// File: rtl/aes128_dec_pkg.sv
// AES-128 decryption control: shared state encoding and strobe decode.
// Unused state encodings (3'd7, and RESTORE when restore is disabled) are illegal.
package aes128_dec_pkg;

  localparam int NROUNDS_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_KE      = 3'd1,
    ST_DEC     = 3'd2,
    ST_RESTORE = 3'd3,
    ST_OUT     = 3'd4,
    ST_UNMASK  = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  typedef struct packed {
    logic ready;
    logic ke;
    logic dec;
    logic restore;
    logic out;
    logic unmask;
    logic done;
  } strobe_t;

  function automatic strobe_t decode_state(state_t s);
    strobe_t v;
    v = '0;
    case (s)
      ST_IDLE:    v.ready   = 1'b1;
      ST_KE:      v.ke      = 1'b1;
      ST_DEC:     v.dec     = 1'b1;
      ST_RESTORE: v.restore = 1'b1;
      ST_OUT:     v.out     = 1'b1;
      ST_UNMASK:  v.unmask  = 1'b1;
      ST_DONE:    v.done    = 1'b1;
      default:    v         = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes128_dec_round_cnt.sv
// Round counter shared by the forward key expansion and inverse round phases.
// Flags the last round and any value outside the legal round range.
module aes128_dec_round_cnt #(
  parameter logic [3:0] NROUNDS = 4'd10
) (
  input  logic       clk_i,
  input  logic       arst_ni,
  input  logic       clr_i,
  input  logic       en_i,
  output logic [3:0] rnd_o,
  output logic       term_o,
  output logic       oor_o
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign rnd_o  = r_cnt;
  assign term_o = (r_cnt == NROUNDS - 4'd1);
  assign oor_o  = (r_cnt >= NROUNDS);

endmodule

// File: rtl/aes128_dec_control.sv
// Sequencer for AES-128 decryption: optional forward key expansion, ten
// inverse rounds, share restore, output write and unmask.
module aes128_dec_control
  import aes128_dec_pkg::*;
#(
  parameter logic [3:0] NROUNDS       = 4'(NROUNDS_DEF),
  parameter bit         SHARE_RESTORE = 1'b1
) (
  input  logic clk_i,
  input  logic arst_ni,
  input  logic start_i,
  input  logic use_prepared_key,
  input  logic key_load_i,
  output logic done_o,
  output logic ready_o,
  output logic key_valid_o,
  output logic error_o,
  output logic ctrl_st_ke,
  output logic ctrl_st_entry_ke,
  output logic ctrl_st_decode,
  output logic ctrl_st_ike,
  output logic ctrl_st_entry,
  output logic ctrl_last,
  output logic ctrl_st_restore,
  output logic ctrl_st_out,
  output logic ctrl_st_unmask
);

  state_t     r_state;
  logic       r_key_valid;
  logic       r_error;
  logic [3:0] w_rnd;
  logic       w_term;
  logic       w_oor;
  logic       w_in_rounds;
  logic       w_bad_enc;
  logic       w_illegal;
  logic       w_cnt_en;
  strobe_t    w_stb;

  assign w_in_rounds = (r_state == ST_KE) || (r_state == ST_DEC);
  assign w_bad_enc   = !(r_state inside {ST_IDLE, ST_KE, ST_DEC, ST_RESTORE,
                                         ST_OUT, ST_UNMASK, ST_DONE})
                    || (!SHARE_RESTORE && r_state == ST_RESTORE);
  assign w_illegal   = w_bad_enc || (w_in_rounds && w_oor);
  assign w_cnt_en    = w_in_rounds && !w_term && !w_illegal;

  // Counter rests at zero outside the round phases, so every phase enters at 0.
  aes128_dec_round_cnt #(.NROUNDS(NROUNDS)) u_cnt (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .clr_i  (!w_cnt_en),
    .en_i   (w_cnt_en),
    .rnd_o  (w_rnd),
    .term_o (w_term),
    .oor_o  (w_oor)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      r_state     <= ST_IDLE;
      r_key_valid <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_illegal) begin
      r_state     <= ST_IDLE;
      r_key_valid <= 1'b0;
      r_error     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE:
          if (start_i)
            r_state <= (use_prepared_key && r_key_valid) ? ST_DEC : ST_KE;
        ST_KE:
          if (w_term) r_state <= ST_DEC;
        ST_DEC:
          if (w_term) r_state <= SHARE_RESTORE ? ST_RESTORE : ST_OUT;
        ST_RESTORE: r_state <= ST_OUT;
        ST_OUT:     r_state <= ST_UNMASK;
        ST_UNMASK:  r_state <= ST_DONE;
        ST_DONE:    r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
      // A new key always wins over the key expansion finishing.
      if (key_load_i)
        r_key_valid <= 1'b0;
      else if (r_state == ST_KE && w_term)
        r_key_valid <= 1'b1;
    end
  end

  assign w_stb = w_illegal ? '0 : decode_state(r_state);

  assign ready_o          = w_stb.ready;
  assign ctrl_st_ke       = w_stb.ke;
  assign ctrl_st_entry_ke = w_stb.ke && (w_rnd == 4'd0);
  assign ctrl_st_decode   = w_stb.dec;
  assign ctrl_st_ike      = w_stb.dec;
  assign ctrl_st_entry    = w_stb.dec && (w_rnd == 4'd0);
  assign ctrl_last        = w_stb.dec && w_term;
  assign ctrl_st_restore  = w_stb.restore;
  assign ctrl_st_out      = w_stb.out;
  assign ctrl_st_unmask   = w_stb.unmask;
  assign done_o           = w_stb.done;
  assign key_valid_o      = r_key_valid;
  assign error_o          = r_error;

endmodule
